// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 16x-oversampled UART receiver with mid-bit sampling and framing check
module uart_rx_oversampled #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done,
  output logic            frame_err,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic rx_m, rx_s, rx_prev;
  logic [4:0] tick_cnt, tick_n;
  logic [3:0] bit_cnt, bit_n;
  logic [DBIT-1:0] shreg, sh_n, dout_n;
  logic done_n, ferr_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      dout      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_prev   <= rx_s;
      tick_cnt  <= tick_n;
      bit_cnt   <= bit_n;
      shreg     <= sh_n;
      dout      <= dout_n;
      rx_done   <= done_n;
      frame_err <= ferr_n;
    end
  end
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    dout_n  = dout;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: if (rx_prev && !rx_s) begin
        state_n = START;
        tick_n  = '0;
      end
      START: if (s_tick) begin
        if (tick_cnt == 5'd7) begin
          state_n = rx_s ? IDLE : DATA;
          tick_n  = '0;
          bit_n   = '0;
        end else tick_n = tick_cnt + 5'd1;
      end
      DATA: if (s_tick) begin
        if (tick_cnt == 5'd15) begin
          sh_n    = {rx_s, shreg[DBIT-1:1]};
          tick_n  = '0;
          bit_n   = bit_cnt + 4'd1;
          state_n = (bit_cnt == 4'(DBIT-1)) ? STOP : DATA;
        end else tick_n = tick_cnt + 5'd1;
      end
      STOP: if (s_tick) begin
        if (tick_cnt == 5'(SB_TICK-1)) begin
          state_n = IDLE;
          tick_n  = '0;
          dout_n  = rx_s ? shreg : dout;
          done_n  = rx_s;
          ferr_n  = !rx_s;
        end else tick_n = tick_cnt + 5'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: directed frames with a byte scoreboard checked on every rx_done
module tb_uart_rx_oversampled;
  logic clk = 1'b0, reset = 1'b1, s_tick = 1'b0, line = 1'b1, sel7 = 1'b0;
  logic rx, rx7;
  logic [7:0] dout;
  logic [6:0] dout_a, dout_b;
  logic rx_done, frame_err, busy, done_a, ferr_a, busy_a, done_b, ferr_b, busy_b;
  int n_chk = 0, n_fail = 0, n_done = 0, n_ferr = 0, cyc = 0, tdiv = 0;
  int t_a = -1, t_b = -1, n_a = 0, n_b = 0;
  logic [6:0] d_a, d_b;
  logic prev_pulse = 1'b0;
  logic [7:0] exp_q[$];

  assign rx  = sel7 ? 1'b1 : line;
  assign rx7 = sel7 ? line : 1'b1;

  uart_rx_oversampled dut (.clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx),
    .dout(dout), .rx_done(rx_done), .frame_err(frame_err), .busy(busy));
  uart_rx_oversampled #(.DBIT(7), .SB_TICK(16)) dut_a (.clk(clk), .reset(reset), .s_tick(s_tick),
    .rx(rx7), .dout(dout_a), .rx_done(done_a), .frame_err(ferr_a), .busy(busy_a));
  uart_rx_oversampled #(.DBIT(7), .SB_TICK(32)) dut_b (.clk(clk), .reset(reset), .s_tick(s_tick),
    .rx(rx7), .dout(dout_b), .rx_done(done_b), .frame_err(ferr_b), .busy(busy_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    tdiv++;
    s_tick = (tdiv % 4 == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (!reset) begin
    if (rx_done) begin
      n_done++;
      chk("unexpected_rx_done", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("dout_on_done", 32'(dout), 32'(exp_q.pop_front()));
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("done_with_ferr", 32'(frame_err), 32'd0);
    end
    if (frame_err) begin
      n_ferr++;
      chk("busy_at_ferr", 32'(busy), 32'd0);
    end
    if (rx_done || frame_err) chk("back_to_back_pulse", 32'(prev_pulse), 32'd0);
    prev_pulse = rx_done | frame_err;
    if (done_a) begin n_a++; t_a = cyc; d_a = dout_a; end
    if (done_b) begin n_b++; t_b = cyc; d_b = dout_b; end
  end

  task automatic send(input logic [8:0] d, input int nb, input bit stop, input int nstop);
    line = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      line = d[i];
      repeat (64) @(negedge clk);
    end
    line = stop;
    repeat (64 * nstop) @(negedge clk);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_rx_done", 32'(rx_done), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (64) @(negedge clk);

    exp_q.push_back(8'hA5);
    send(9'h0A5, 8, 1'b1, 1);
    repeat (16) @(negedge clk);
    chk("t1_done_cnt", 32'(n_done), 32'd1);
    chk("t1_ferr_cnt", 32'(n_ferr), 32'd0);
    chk("t1_dout", 32'(dout), 32'hA5);

    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send(9'h000, 8, 1'b1, 1);
    send(9'h0FF, 8, 1'b1, 1);
    repeat (16) @(negedge clk);
    chk("t2_done_cnt", 32'(n_done), 32'd3);
    chk("t2_dout", 32'(dout), 32'hFF);
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    line = 1'b0;
    repeat (12) @(negedge clk);
    line = 1'b1;
    repeat (8) @(negedge clk);
    chk("t3_busy_in_start", 32'(busy), 32'd1);
    repeat (64) @(negedge clk);
    chk("t3_busy_after", 32'(busy), 32'd0);
    chk("t3_no_done", 32'(n_done), 32'd3);
    chk("t3_no_ferr", 32'(n_ferr), 32'd0);
    chk("t3_dout", 32'(dout), 32'hFF);

    send(9'h03C, 8, 1'b0, 1);
    chk("t4_ferr_cnt", 32'(n_ferr), 32'd1);
    chk("t4_no_done", 32'(n_done), 32'd3);
    chk("t4_dout_kept", 32'(dout), 32'hFF);
    repeat (40 * 64) @(negedge clk);
    chk("t4_break_ferr", 32'(n_ferr), 32'd1);
    chk("t4_break_done", 32'(n_done), 32'd3);
    chk("t4_break_busy", 32'(busy), 32'd0);
    line = 1'b1;
    repeat (64) @(negedge clk);
    exp_q.push_back(8'h81);
    send(9'h081, 8, 1'b1, 1);
    repeat (16) @(negedge clk);
    chk("t4_done_cnt", 32'(n_done), 32'd4);
    chk("t4_dout_81", 32'(dout), 32'h81);

    line = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      line = (8'h55 >> i) & 8'h01;
      repeat (64) @(negedge clk);
    end
    line = 1'b1;
    repeat (32) @(negedge clk);
    chk("t5_busy_before_rst", 32'(busy), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_dout", 32'(dout), 32'd0);
    reset = 1'b0;
    repeat (128) @(negedge clk);
    chk("t5_abort_no_done", 32'(n_done), 32'd4);
    exp_q.push_back(8'h12);
    send(9'h012, 8, 1'b1, 1);
    repeat (16) @(negedge clk);
    chk("t5_done_cnt", 32'(n_done), 32'd5);
    chk("t5_dout_12", 32'(dout), 32'h12);
    chk("t5_ferr_cnt", 32'(n_ferr), 32'd1);

    sel7 = 1'b1;
    repeat (64) @(negedge clk);
    send(9'h05A, 7, 1'b1, 2);
    repeat (64) @(negedge clk);
    chk("t6_done_a", 32'(n_a), 32'd1);
    chk("t6_done_b", 32'(n_b), 32'd1);
    chk("t6_dout_a", 32'(d_a), 32'h5A);
    chk("t6_dout_b", 32'(d_b), 32'h5A);
    chk("t6_stop_delay", 32'(t_b - t_a), 32'd64);
    chk("t6_main_quiet", 32'(n_done), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
